dram_cmd_scheduler: RTL and testbench

In-order, open-page DRAM command scheduler between the memory request queue and `command_sender`. It accepts one request at a time and splits the request address into row, column, bank group and bank. It tracks the open row and per-bank timing for every bank, then issues the minimal PRECHARGE / ACTIVATE / READ / WRITE sequence while honouring bank timing and data-bus occupancy.

---
 rtl/dram_cmd_scheduler.sv | 268 ++++++++++++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_scheduler.sv
// In-order open-page DRAM command scheduler: one request at a time, emitting
// the minimal PRECHARGE/ACTIVATE/READ/WRITE sequence under bank and bus timing.

module dram_bank_entry #(
  parameter int ROW_BITS = 8,
  parameter int TW       = 5,
  parameter int PRE_LOAD = 4,
  parameter int ACT_LOAD = 7
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                pre_i,
  input  logic                act_i,
  input  logic [ROW_BITS-1:0] row_i,
  output logic                open_o,
  output logic [ROW_BITS-1:0] row_o,
  output logic                idle_o
);
  logic                open_q, open_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [TW-1:0]       tmr_q, tmr_d;

  // Timer loads L-1 so the dependent command lands exactly L cycles later.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    tmr_d  = (tmr_q == '0) ? tmr_q : tmr_q - TW'(1);
    if (pre_i) begin
      open_d = 1'b0;
      tmr_d  = TW'(PRE_LOAD);
    end else if (act_i) begin
      open_d = 1'b1;
      row_d  = row_i;
      tmr_d  = TW'(ACT_LOAD);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      open_q <= 1'b0;
      row_q  <= '0;
      tmr_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      tmr_q  <= tmr_d;
    end
  end

  assign open_o = open_q;
  assign row_o  = row_q;
  assign idle_o = (tmr_q == '0);
endmodule

module dram_cmd_scheduler #(
  parameter int CAS_LATENCY        = 22,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BURST_CYCLES       = 4,
  parameter int BANK_GROUPS        = 2,
  parameter int BANKS_PER_GROUP    = 4,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int PADDR_BITS         = 64
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                req_valid_in,
  output logic                                req_ready_out,
  input  logic                                req_write_in,
  input  logic [PADDR_BITS-1:0]               req_addr_in,
  input  logic [7:0][63:0]                    req_data_in,
  output logic                                cmd_valid_out,
  output logic [2:0]                          cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]      bank_group_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0]  bank_out,
  output logic [ROW_BITS-1:0]                 row_out,
  output logic [COL_BITS-1:0]                 col_out,
  output logic [7:0][63:0]                    wdata_out,
  output logic                                done_out,
  output logic                                done_hit_out
);
  localparam int BKW    = $clog2(BANKS_PER_GROUP);
  localparam int BGW    = $clog2(BANK_GROUPS);
  localparam int IW     = BGW + BKW;
  localparam int NB     = 1 << IW;
  localparam int FW     = ROW_BITS + BGW + BKW + COL_BITS;
  localparam int RD_GAP = CAS_LATENCY + BURST_CYCLES;
  localparam int MAXG0  = (RD_GAP > ACTIVATION_LATENCY) ? RD_GAP : ACTIVATION_LATENCY;
  localparam int MAXL   = (MAXG0 > PRECHARGE_LATENCY) ? MAXG0 : PRECHARGE_LATENCY;
  localparam int TW     = $clog2(MAXL + 1);

  localparam logic [2:0] CMD_READ  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_ACT   = 3'd2;
  localparam logic [2:0] CMD_PRE   = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ACT, S_COL} state_t;

  // Field order mirrors the address layout above the 3-bit byte offset.
  typedef struct packed {
    logic                write;
    logic [ROW_BITS-1:0] row;
    logic [BGW-1:0]      bg;
    logic [BKW-1:0]      bank;
    logic [COL_BITS-1:0] col;
  } req_t;

  state_t          state_q, state_d;
  req_t            req_q, req_d, in_req;
  logic            hit_q, hit_d;
  logic            ready_q, ready_d;
  logic [TW-1:0]   col_tmr_q, col_tmr_d;
  logic [7:0][63:0] wdata_q, wdata_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [BGW-1:0]  bg_q, bg_d;
  logic [BKW-1:0]  bank_q, bank_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic            done_q, done_d, done_hit_q, done_hit_d;
  logic            pre_issue, act_issue;

  logic [NB-1:0]               bk_open, bk_idle;
  logic [NB-1:0][ROW_BITS-1:0] bk_row;
  logic [IW-1:0]               in_idx, cur_idx;
  logic                        unused_addr;

  assign in_req      = {req_write_in, req_addr_in[3 +: FW]};
  assign in_idx      = {in_req.bg, in_req.bank};
  assign cur_idx     = {req_q.bg, req_q.bank};
  assign unused_addr = ^{req_addr_in[PADDR_BITS-1:3+FW], req_addr_in[2:0]};

  for (genvar i = 0; i < NB; i++) begin : g_bank
    dram_bank_entry #(
      .ROW_BITS (ROW_BITS),
      .TW       (TW),
      .PRE_LOAD (PRECHARGE_LATENCY - 1),
      .ACT_LOAD (ACTIVATION_LATENCY - 1)
    ) u_bank (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .pre_i  (pre_issue && (cur_idx == IW'(i))),
      .act_i  (act_issue && (cur_idx == IW'(i))),
      .row_i  (req_q.row),
      .open_o (bk_open[i]),
      .row_o  (bk_row[i]),
      .idle_o (bk_idle[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    hit_d       = hit_q;
    wdata_d     = wdata_q;
    col_tmr_d   = (col_tmr_q == '0) ? col_tmr_q : col_tmr_q - TW'(1);
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    bg_d        = bg_q;
    bank_d      = bank_q;
    row_d       = row_q;
    col_d       = col_q;
    done_d      = 1'b0;
    done_hit_d  = 1'b0;
    pre_issue   = 1'b0;
    act_issue   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_in && ready_q) begin
          req_d   = in_req;
          wdata_d = req_data_in;
          hit_d   = 1'b0;
          if (!bk_open[in_idx]) begin
            state_d = S_ACT;
          end else if (bk_row[in_idx] == in_req.row) begin
            state_d = S_COL;
            hit_d   = 1'b1;
          end else begin
            state_d = S_PRE;
          end
        end
      end
      S_PRE: begin
        if (bk_idle[cur_idx]) begin
          pre_issue   = 1'b1;
          cmd_valid_d = 1'b1;
          cmd_d       = CMD_PRE;
          state_d     = S_ACT;
        end
      end
      S_ACT: begin
        if (bk_idle[cur_idx]) begin
          act_issue   = 1'b1;
          cmd_valid_d = 1'b1;
          cmd_d       = CMD_ACT;
          state_d     = S_COL;
        end
      end
      S_COL: begin
        if (bk_idle[cur_idx] && (col_tmr_q == '0)) begin
          cmd_valid_d = 1'b1;
          cmd_d       = req_q.write ? CMD_WRITE : CMD_READ;
          done_d      = 1'b1;
          done_hit_d  = hit_q;
          col_tmr_d   = req_q.write ? TW'(BURST_CYCLES) : TW'(RD_GAP - 1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cmd_valid_d) begin
      bg_d   = req_q.bg;
      bank_d = req_q.bank;
      row_d  = req_q.row;
      col_d  = req_q.col;
    end
    // Ready lags the column command by a cycle so acceptance never overlaps a command.
    ready_d = (state_d == S_IDLE) && !cmd_valid_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      hit_q       <= 1'b0;
      ready_q     <= 1'b0;
      col_tmr_q   <= '0;
      wdata_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      bg_q        <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      done_q      <= 1'b0;
      done_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      hit_q       <= hit_d;
      ready_q     <= ready_d;
      col_tmr_q   <= col_tmr_d;
      wdata_q     <= wdata_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      bg_q        <= bg_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      done_q      <= done_d;
      done_hit_q  <= done_hit_d;
    end
  end

  assign req_ready_out  = ready_q;
  assign cmd_valid_out  = cmd_valid_q;
  assign cmd_out        = cmd_q;
  assign bank_group_out = bg_q;
  assign bank_out       = bank_q;
  assign row_out        = row_q;
  assign col_out        = col_q;
  assign wdata_out      = wdata_q;
  assign done_out       = done_q;
  assign done_hit_out   = done_hit_q;
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: directed scenarios plus random requests checked
// against a timestamp-based model of bank/bus availability.

module tb_dram_cmd_scheduler;
  localparam int CAS = 22, ACTL = 8, PREL = 5, BURST = 4;

  logic            clk = 1'b0;
  logic            rst, req_valid, req_ready, req_write;
  logic [63:0]     req_addr;
  logic [7:0][63:0] req_data, wdata;
  logic            cmd_valid, done, done_hit;
  logic [2:0]      cmd;
  logic [0:0]      bg;
  logic [1:0]      bank;
  logic [7:0]      row;
  logic [3:0]      col;

  always #5 clk = ~clk;

  dram_cmd_scheduler dut (
    .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_write_in(req_write), .req_addr_in(req_addr), .req_data_in(req_data),
    .cmd_valid_out(cmd_valid), .cmd_out(cmd), .bank_group_out(bg), .bank_out(bank),
    .row_out(row), .col_out(col), .wdata_out(wdata), .done_out(done),
    .done_hit_out(done_hit)
  );

  int tests = 0, fails = 0, cyc = 0;
  bit m_open [8];
  int m_row  [8];
  int m_bank_rdy [8];
  int m_col_rdy;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_open[i] = 1'b0; m_row[i] = 0; m_bank_rdy[i] = 0;
    end
    m_col_rdy = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_ready", req_ready, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_done", {done, done_hit}, 0);
      chk("rst_fields", {cmd, bg, bank, row, col}, 0);
      chk("rst_wdata", |wdata, 0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_ready", req_ready, 1);
    model_reset();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("idle_cmd_valid", cmd_valid, 0);
      chk("idle_ready", req_ready, 1);
    end
  endtask

  task automatic do_req(input bit wr, input logic [63:0] addr, input logic [7:0][63:0] data);
    int guard, t, b, r, c, pre_t, act_t, col_t;
    bit hit;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 60) begin tick(); guard++; end
    chk("accept_ready", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_data = data;
    tick();
    t = cyc;
    b = int'((addr >> 7) % 8);
    r = int'((addr >> 10) % 256);
    c = int'((addr >> 3) % 16);
    pre_t = -1; act_t = -1;
    hit = m_open[b] && (m_row[b] == r);
    if (!m_open[b]) begin
      act_t = max2(t + 1, m_bank_rdy[b]);
      col_t = max2(act_t + ACTL, m_col_rdy);
    end else if (hit) begin
      col_t = max2(max2(t + 1, m_bank_rdy[b]), m_col_rdy);
    end else begin
      pre_t = max2(t + 1, m_bank_rdy[b]);
      act_t = pre_t + PREL;
      col_t = max2(act_t + ACTL, m_col_rdy);
    end
    if (act_t >= 0) begin
      m_open[b] = 1'b1; m_row[b] = r; m_bank_rdy[b] = act_t + ACTL;
    end
    m_col_rdy = col_t + (wr ? BURST + 1 : CAS + BURST);

    while (cyc < col_t) begin
      // Junk on the request port while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) req_data[i] = {$urandom, $urandom};
      tick();
      chk("busy_ready", req_ready, 0);
      chk("cmd_valid", cmd_valid, (cyc == pre_t) || (cyc == act_t) || (cyc == col_t));
      chk("done", done, cyc == col_t);
      if (cyc == pre_t) begin
        chk("pre_cmd", cmd, 3);
        chk("pre_bank", {bg, bank}, b);
        chk("pre_row", row, r);
      end
      if (cyc == act_t) begin
        chk("act_cmd", cmd, 2);
        chk("act_bank", {bg, bank}, b);
        chk("act_row", row, r);
      end
      if (cyc == col_t) begin
        chk("col_cmd", cmd, wr ? 1 : 0);
        chk("col_bank", {bg, bank}, b);
        chk("col_row", row, r);
        chk("col_col", col, c);
        chk("done_hit", done_hit, hit);
        if (wr) for (int i = 0; i < 8; i++) chk("wdata_beat", wdata[i], data[i]);
      end
    end
    req_valid = 1'b0;
    tick();
    chk("ready_back", req_ready, 1);
    chk("after_col_valid", cmd_valid, 0);
  endtask

  initial begin
    logic [7:0][63:0] d;
    logic [63:0] a;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    d = '0;
    do_reset();

    do_req(1'b0, 64'h1400, d);
    do_req(1'b0, 64'h1408, d);
    idle(30);
    do_req(1'b0, 64'h1800, d);
    idle(30);
    for (int i = 0; i < 8; i++) d[i] = 64'(i);
    do_req(1'b1, 64'h1400, d);
    do_req(1'b0, 64'h1400, '0);

    do_reset();
    do_req(1'b0, 64'h0000, '0);
    do_req(1'b0, 64'h0080, '0);

    // Reset while the request waits for its column command.
    do_reset();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h1400;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_act_valid", cmd_valid, 1);
    chk("mid_act_cmd", cmd, 2);
    repeat (3) begin
      tick();
      chk("mid_wait_valid", cmd_valid, 0);
    end
    do_reset();
    idle(20);
    do_req(1'b0, 64'h1400, '0);

    for (int n = 0; n < 40; n++) begin
      a = (64'($urandom_range(0, 3)) << 10) | (64'($urandom_range(0, 7)) << 7) |
          (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(0, 7)) |
          (64'($urandom) << 18);
      for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
      do_req(1'($urandom_range(0, 1)), a, d);
      idle($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
